// File: rtl/r88_pkg.sv
// rtl/r88_pkg.sv - shared widths, FSM encoding and constants for the Rocket88 memory controller
package r88_pkg;

  localparam int R88_ADDR_W = 16;
  localparam int R88_DATA_W = 8;

  // Read data returned when the external cycle times out
  localparam logic [R88_DATA_W-1:0] R88_ERR_FILL = 8'hFF;

  typedef enum logic [2:0] {
    MC_IDLE   = 3'd0,
    MC_SETUP  = 3'd1,
    MC_ACCESS = 3'd2,
    MC_DONE   = 3'd3,
    MC_HOLD   = 3'd4
  } mc_state_e;

endpackage

// File: rtl/r88_memctl_if.sv
// rtl/r88_memctl_if.sv - decoder-side and external-memory-side signal bundle of r88_memctl
interface r88_memctl_if;

  // Decoder side
  logic                            readMem;
  logic                            writeMem;
  logic                            mc_use_regAddr;
  logic [r88_pkg::R88_ADDR_W-1:0]  regAddr;
  logic                            mc_write_low;
  logic                            mc_write_high;
  logic [r88_pkg::R88_DATA_W-1:0]  intDIn;
  logic [r88_pkg::R88_DATA_W-1:0]  intDOut;
  logic                            intDOe;
  logic                            memReady;
  logic                            busError;

  // External memory side
  logic [r88_pkg::R88_ADDR_W-1:0]  extAddr;
  logic [r88_pkg::R88_DATA_W-1:0]  extDataOut;
  logic [r88_pkg::R88_DATA_W-1:0]  extDataIn;
  logic                            extRd;
  logic                            extWr;
  logic                            extAck;

  // Decoder plus external memory, i.e. everything around the controller
  modport master (
    output readMem, writeMem, mc_use_regAddr, regAddr, mc_write_low, mc_write_high, intDIn,
    output extDataIn, extAck,
    input  intDOut, intDOe, memReady, busError, extAddr, extDataOut, extRd, extWr
  );

  // The controller itself
  modport slave (
    input  readMem, writeMem, mc_use_regAddr, regAddr, mc_write_low, mc_write_high, intDIn,
    input  extDataIn, extAck,
    output intDOut, intDOe, memReady, busError, extAddr, extDataOut, extRd, extWr
  );

endinterface

// File: rtl/r88_addr_latch.sv
// rtl/r88_addr_latch.sv - byte-loadable 16-bit address latch with register-file source mux
module r88_addr_latch
  import r88_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_low_i,
  input  logic                  wr_high_i,
  input  logic [R88_DATA_W-1:0] din_i,
  input  logic                  use_reg_i,
  input  logic [R88_ADDR_W-1:0] reg_addr_i,
  output logic [R88_ADDR_W-1:0] addr_o
);

  logic [R88_ADDR_W-1:0] latch_q;
  logic [R88_ADDR_W-1:0] latch_d;

  // Each byte loads independently; both may load in the same cycle
  always_comb begin
    latch_d = latch_q;
    if (wr_low_i)  latch_d[7:0]  = din_i;
    if (wr_high_i) latch_d[15:8] = din_i;
  end

  // Latch storage; a request sampled on the same edge still sees the old value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) latch_q <= '0;
    else         latch_q <= latch_d;
  end

  // Source select feeds the controller's address register, never an output directly
  assign addr_o = use_reg_i ? reg_addr_i : latch_q;

endmodule

// File: rtl/r88_memctl.sv
// rtl/r88_memctl.sv - single-request external memory cycle engine with wait states and timeout
module r88_memctl
  import r88_pkg::*;
#(
  parameter int MIN_WAIT    = 0,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic         sysClock,
  input  logic         resetReqN,
  r88_memctl_if.slave  bus
);

  localparam logic [4:0] MIN_W5 = 5'(MIN_WAIT);
  localparam logic [3:0] TMO    = 4'(ACK_TIMEOUT);

  mc_state_e             state_q;
  logic [R88_ADDR_W-1:0] addr_d;
  logic [R88_ADDR_W-1:0] addr_q;
  logic [R88_DATA_W-1:0] wdata_q;
  logic [R88_DATA_W-1:0] read_data_q;
  logic                  rd_q;
  logic                  err_q;
  logic [3:0]            cnt_q;
  logic                  min_ok;

  logic [R88_ADDR_W-1:0] ext_addr_q;
  logic [R88_DATA_W-1:0] ext_dout_q;
  logic                  ext_rd_q;
  logic                  ext_wr_q;
  logic [R88_DATA_W-1:0] int_dout_q;
  logic                  int_doe_q;
  logic                  mem_ready_q;
  logic                  bus_error_q;

  r88_addr_latch u_addr_latch (
    .clk_i      (sysClock),
    .rst_ni     (resetReqN),
    .wr_low_i   (bus.mc_write_low),
    .wr_high_i  (bus.mc_write_high),
    .din_i      (bus.intDIn),
    .use_reg_i  (bus.mc_use_regAddr),
    .reg_addr_i (bus.regAddr),
    .addr_o     (addr_d)
  );

  // cnt_q >= MIN_WAIT, written so that MIN_WAIT = 0 is not a constant compare
  assign min_ok = ({1'b0, cnt_q} + 5'd1) > MIN_W5;

  // Request FSM with wait counter; every bus output is a register updated here
  always_ff @(posedge sysClock or negedge resetReqN) begin
    if (!resetReqN) begin
      state_q     <= MC_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      rd_q        <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      ext_addr_q  <= '0;
      ext_dout_q  <= '0;
      ext_rd_q    <= 1'b0;
      ext_wr_q    <= 1'b0;
      int_dout_q  <= '0;
      int_doe_q   <= 1'b0;
      mem_ready_q <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      mem_ready_q <= 1'b0;
      bus_error_q <= 1'b0;
      case (state_q)
        MC_IDLE: begin
          int_doe_q  <= 1'b0;
          int_dout_q <= '0;
          if (bus.readMem && bus.writeMem) begin
            // Conflicting request: flag it and wait for the decoder to let go
            bus_error_q <= 1'b1;
            rd_q        <= 1'b0;
            state_q     <= MC_HOLD;
          end else if (bus.readMem || bus.writeMem) begin
            addr_q <= addr_d;
            rd_q   <= bus.readMem;
            err_q  <= 1'b0;
            if (bus.writeMem) wdata_q <= bus.intDIn;
            state_q <= MC_SETUP;
          end
        end
        MC_SETUP: begin
          ext_addr_q <= addr_q;
          if (!rd_q) ext_dout_q <= wdata_q;
          ext_rd_q <= rd_q;
          ext_wr_q <= !rd_q;
          cnt_q    <= '0;
          state_q  <= MC_ACCESS;
        end
        MC_ACCESS: begin
          cnt_q <= cnt_q + 4'd1;
          // A qualifying ack beats a timeout landing on the same cycle
          if (min_ok && bus.extAck) begin
            if (rd_q) read_data_q <= bus.extDataIn;
            state_q <= MC_DONE;
          end else if (cnt_q == TMO) begin
            read_data_q <= R88_ERR_FILL;
            err_q       <= 1'b1;
            state_q     <= MC_DONE;
          end
        end
        MC_DONE: begin
          ext_rd_q    <= 1'b0;
          ext_wr_q    <= 1'b0;
          mem_ready_q <= 1'b1;
          bus_error_q <= err_q;
          int_doe_q   <= rd_q && bus.readMem;
          int_dout_q  <= (rd_q && bus.readMem) ? read_data_q : '0;
          state_q     <= MC_HOLD;
        end
        MC_HOLD: begin
          // Keep returning read data while the decoder holds the request
          int_doe_q  <= rd_q && bus.readMem;
          int_dout_q <= (rd_q && bus.readMem) ? read_data_q : '0;
          if (!bus.readMem && !bus.writeMem) state_q <= MC_IDLE;
        end
        default: state_q <= MC_IDLE;
      endcase
    end
  end

  assign bus.extAddr    = ext_addr_q;
  assign bus.extDataOut = ext_dout_q;
  assign bus.extRd      = ext_rd_q;
  assign bus.extWr      = ext_wr_q;
  assign bus.intDOut    = int_dout_q;
  assign bus.intDOe     = int_doe_q;
  assign bus.memReady   = mem_ready_q;
  assign bus.busError   = bus_error_q;

endmodule
